down_timer: RTL and testbench

Loadable down-counting timer with start/stop control and a terminal-count pulse.
- Complements the generic up counter: counts a programmed value down to zero, then flags completion.
- Optionally auto-reloads for periodic ticks.
- Used by control FSMs for timeouts and periodic strobes; shares the same clock-enable convention as the other counters in the datapath.

---
 rtl/down_timer.sv | 104 ++++++++++
 tb/tb_down_timer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counting timer with start/stop, optional auto-reload and a one-cycle terminal-count pulse.
// Define DOWN_TIMER_TC_COUNT_EN to add a saturating tc_count output that counts terminal-count pulses.
module down_timer #(
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            load,
    input  logic [NBIT-1:0] load_val,
    input  logic            start,
    input  logic            stop,
    input  logic            auto_reload,
    output logic [NBIT-1:0] cnt,
    output logic            busy,
`ifdef DOWN_TIMER_TC_COUNT_EN
    output logic [NBIT-1:0] tc_count,
`endif
    output logic            tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NBIT-1:0] ZERO = '0;
    localparam logic [NBIT-1:0] ONE  = NBIT'(1);

    state_t          state, state_nxt;
    logic [NBIT-1:0] cnt_nxt;
    logic [NBIT-1:0] reload_q, reload_nxt;
    logic            tc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= ZERO;
            reload_q <= ZERO;
            tc       <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            reload_q <= reload_nxt;
            tc       <= tc_nxt;
        end
    end

    // Commands resolve as load > stop > start; tc_nxt defaults low so tc never outlives one clk cycle.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        if (clk_en) begin
            if (load) begin
                reload_nxt = load_val;
                cnt_nxt    = load_val;
                state_nxt  = IDLE;
            end else if (stop) begin
                if (state == RUN) begin
                    state_nxt = IDLE;
                end
            end else if (start && (state != RUN)) begin
                if (reload_q == ZERO) begin
                    state_nxt = DONE;
                    cnt_nxt   = ZERO;
                    tc_nxt    = 1'b1;
                end else begin
                    state_nxt = RUN;
                    cnt_nxt   = reload_q;
                end
            end else if (state == RUN) begin
                if (cnt > ONE) begin
                    cnt_nxt = cnt - ONE;
                end else if (cnt == ONE) begin
                    cnt_nxt = ZERO;
                    tc_nxt  = 1'b1;
                end else if (auto_reload) begin
                    cnt_nxt = reload_q;
                end else begin
                    state_nxt = DONE;
                end
            end
        end
    end

    assign busy = (state == RUN);

`ifdef DOWN_TIMER_TC_COUNT_EN
    // Counts at the same edge that raises tc, so tc_count already includes the pulse being shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_count <= ZERO;
        end else if (clk_en && load) begin
            tc_count <= ZERO;
        end else if (tc_nxt && (tc_count != {NBIT{1'b1}})) begin
            tc_count <= tc_count + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (NBIT=4): directed scenarios plus randomized traffic
// compared against a behavioural model of the timer held in the bench.
module tb_down_timer;

    localparam int NBIT = 4;
    localparam int MAXV = (1 << NBIT) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            load;
    logic [NBIT-1:0] load_val;
    logic            start;
    logic            stop;
    logic            auto_reload;
    logic [NBIT-1:0] cnt;
    logic            busy;
    logic            tc;
`ifdef DOWN_TIMER_TC_COUNT_EN
    logic [NBIT-1:0] tc_count;
`endif

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = running, 2 = done.
    int m_mode;
    int m_cnt;
    int m_reload;
    int m_tc;
    int m_tcc;

    down_timer #(.NBIT(NBIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .cnt        (cnt),
        .busy       (busy),
`ifdef DOWN_TIMER_TC_COUNT_EN
        .tc_count   (tc_count),
`endif
        .tc         (tc)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode   = 0;
        m_cnt    = 0;
        m_reload = 0;
        m_tc     = 0;
        m_tcc    = 0;
    endfunction

    function automatic void model_edge();
        int pulse;
        pulse = 0;
        if (clk_en) begin
            if (load) begin
                m_reload = int'(load_val);
                m_cnt    = int'(load_val);
                m_mode   = 0;
                m_tcc    = 0;
            end else if (stop) begin
                if (m_mode == 1) m_mode = 0;
            end else if (start && m_mode != 1) begin
                if (m_reload == 0) begin
                    m_mode = 2;
                    m_cnt  = 0;
                    pulse  = 1;
                end else begin
                    m_mode = 1;
                    m_cnt  = m_reload;
                end
            end else if (m_mode == 1) begin
                if (m_cnt >= 2) begin
                    m_cnt = m_cnt - 1;
                end else if (m_cnt == 1) begin
                    m_cnt = 0;
                    pulse = 1;
                end else if (auto_reload) begin
                    m_cnt = m_reload;
                end else begin
                    m_mode = 2;
                end
            end
        end
        m_tc = pulse;
        if (pulse == 1 && m_tcc < MAXV) m_tcc = m_tcc + 1;
    endfunction

    task automatic drive(input logic en, input logic ld, input int val,
                         input logic st, input logic sp, input logic ar);
        clk_en      = en;
        load        = ld;
        load_val    = NBIT'(val);
        start       = st;
        stop        = sp;
        auto_reload = ar;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: cnt=%0d busy=%b tc=%b, required 0/0/0", cnt, busy, tc);
        end
        rst = 1'b0;
        drive(1, 1, 7, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (cnt !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_run: cnt=%0d busy=%b, required 5/1", cnt, busy);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: cnt=%0d busy=%b tc=%b, required 0/0/0", cnt, busy, tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: cnt=%0d busy=%b tc=%b, required 0/0/0", cnt, busy, tc);
        end
        rst = 1'b0;
        drive(1, 0, 0, 1, 0, 1);
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_start_zero: cnt=%0d busy=%b tc=%b, required 0/0/1", cnt, busy, tc);
        end
        drive(1, 0, 0, 0, 0, 1);
        checks++;
        if (tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tc_single: tc=%b busy=%b, required 0/0", tc, busy);
        end
    endtask

    task automatic test_one_shot();
        drive(1, 1, 4, 0, 0, 0);
        checks++;
        if (cnt !== 4'd4 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_load: cnt=%0d busy=%b, required 4/0", cnt, busy);
        end
        drive(1, 0, 0, 1, 0, 0);
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (cnt !== NBIT'(4 - k) || busy !== 1'b1 || tc !== (k == 4)) begin
                errors++;
                $display("[TB] FAIL oneshot_step%0d: cnt=%0d busy=%b tc=%b, required %0d/1/%0d",
                         k, cnt, busy, tc, 4 - k, (k == 4));
            end
            if (k < 4) drive(1, 0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_done: cnt=%0d busy=%b tc=%b, required 0/0/0", cnt, busy, tc);
        end
    endtask

    task automatic test_auto_reload();
        int pulses;
        pulses = 0;
        drive(1, 1, 3, 0, 0, 1);
        drive(1, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            drive(1, 0, 0, 0, 0, 1);
            if (tc === 1'b1) pulses++;
            checks++;
            if (cnt !== NBIT'(3 - (k % 4)) || busy !== 1'b1 || tc !== ((k % 4) == 3)) begin
                errors++;
                $display("[TB] FAIL autoreload_step%0d: cnt=%0d busy=%b tc=%b, required %0d/1/%0d",
                         k, cnt, busy, tc, 3 - (k % 4), ((k % 4) == 3));
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("[TB] FAIL autoreload_pulses: got %0d, required 3", pulses);
        end
        repeat (3) drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (tc !== 1'b0 || cnt !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tc_clear_stalled: tc=%b cnt=%0d busy=%b, required 0/0/1", tc, cnt, busy);
        end
    endtask

    task automatic test_stall_stop();
        drive(1, 1, 6, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (cnt !== 4'd4 || tc !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: cnt=%0d tc=%b busy=%b, required 4/0/1", k, cnt, tc, busy);
            end
        end
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        checks++;
        if (cnt !== 4'd2 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_run: cnt=%0d busy=%b tc=%b, required 2/0/0", cnt, busy, tc);
        end
        drive(1, 0, 0, 1, 0, 0);
        checks++;
        if (cnt !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart: cnt=%0d busy=%b, required 6/1", cnt, busy);
        end
        drive(1, 0, 0, 1, 0, 0);
        checks++;
        if (cnt !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_in_run: cnt=%0d busy=%b, required 5/1", cnt, busy);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 9, 1, 1, 0);
        checks++;
        if (cnt !== 4'd9 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL priority_load: cnt=%0d busy=%b tc=%b, required 9/0/0", cnt, busy, tc);
        end
        drive(1, 0, 0, 1, 0, 0);
        checks++;
        if (cnt !== 4'd9 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL priority_reload: cnt=%0d busy=%b, required 9/1", cnt, busy);
        end
    endtask

    task automatic test_boundary();
        int pulses;
        pulses = 0;
        drive(1, 1, 15, 0, 0, 0);
`ifdef DOWN_TIMER_TC_COUNT_EN
        checks++;
        if (tc_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL tccount_load_clear: got %0d, required 0", tc_count);
        end
`endif
        drive(1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (tc === 1'b1) pulses++;
            checks++;
            if (cnt !== NBIT'(15 - k) || tc !== (k == 15)) begin
                errors++;
                $display("[TB] FAIL max_step%0d: cnt=%0d tc=%b, required %0d/%0d", k, cnt, tc, 15 - k, (k == 15));
            end
        end
        repeat (4) begin
            drive(1, 0, 0, 0, 0, 0);
            if (tc === 1'b1) pulses++;
        end
        checks++;
        if (cnt !== 4'd0 || busy !== 1'b0 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL max_nowrap: cnt=%0d busy=%b pulses=%0d, required 0/0/1", cnt, busy, pulses);
        end
`ifdef DOWN_TIMER_TC_COUNT_EN
        pulses = 0;
        drive(1, 1, 1, 0, 0, 1);
        drive(1, 0, 0, 1, 0, 1);
        for (int k = 0; k < 34; k++) begin
            drive(1, 0, 0, 0, 0, 1);
            if (tc === 1'b1) pulses++;
        end
        checks++;
        if (tc_count !== 4'd15 || pulses != 17) begin
            errors++;
            $display("[TB] FAIL tccount_saturate: tc_count=%0d pulses=%0d, required 15/17", tc_count, pulses);
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 6),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1);
            checks++;
            if (cnt !== NBIT'(m_cnt) || busy !== (m_mode == 1) || tc !== (m_tc == 1)) begin
                errors++;
                $display("[TB] FAIL random%0d: cnt=%0d busy=%b tc=%b, required %0d/%0d/%0d",
                         k, cnt, busy, tc, m_cnt, (m_mode == 1), m_tc);
            end
`ifdef DOWN_TIMER_TC_COUNT_EN
            checks++;
            if (tc_count !== NBIT'(m_tcc)) begin
                errors++;
                $display("[TB] FAIL random_tccount%0d: got %0d, required %0d", k, tc_count, m_tcc);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_stall_stop();
        test_priority();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
